bram_stream_reader: RTL



---
 rtl/bram_stream_pkg.sv | 22 ++
 rtl/bram_stream_skid.sv | 75 +++++++
 rtl/bram_stream_reader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/bram_stream_pkg.sv
// Shared types and constants for the BRAM stream reader.
// State encoding, skid-buffer depth and the stall-counter width used by the
// optional performance counter (enabled by BRAM_STREAM_READER_PERF_EN).
package bram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Two entries are enough to absorb the one-cycle BRAM latency at full rate.
  localparam int SKID_DEPTH  = 2;
  localparam int OCC_W       = $clog2(SKID_DEPTH + 1);
  localparam int STALL_CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bram_stream_skid.sv
// Two-entry shift-style FIFO between the BRAM read port and the output stream.
// Entry 0 is always the head, so the stream data comes straight from a
// register. Each entry carries its data word and its last-beat flag.
// Push and pop in the same cycle are both honoured; the parent guarantees
// it never pushes into a full buffer without popping.
module bram_stream_skid
  import bram_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_last_i,
  input  logic                  pop_i,
  output logic [OCC_W-1:0]      occ_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o
);

  logic [DATA_WIDTH-1:0] data_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] data_d [SKID_DEPTH];
  logic                  last_q [SKID_DEPTH];
  logic                  last_d [SKID_DEPTH];
  logic [OCC_W-1:0]      occ_q;
  logic [OCC_W-1:0]      occ_d;
  logic [OCC_W-1:0]      wr_idx;

  // After a simultaneous pop the free slot moves down by one.
  assign wr_idx = occ_q - OCC_W'(pop_i);

  // Next-state for occupancy and every entry: shift on pop, then write on push.
  always_comb begin
    occ_d = occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
    for (int i = 0; i < SKID_DEPTH; i++) begin
      int src;
      src       = (i < SKID_DEPTH - 1) ? i + 1 : i;
      data_d[i] = data_q[i];
      last_d[i] = last_q[i];
      if (pop_i) begin
        data_d[i] = data_q[src];
        last_d[i] = last_q[src];
      end
      if (push_i && (wr_idx == OCC_W'(i))) begin
        data_d[i] = push_data_i;
        last_d[i] = push_last_i;
      end
    end
  end

  // Storage registers; reset empties the buffer and zeroes the head word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
    end else begin
      occ_q <= occ_d;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        data_q[i] <= data_d[i];
        last_q[i] <= last_d[i];
      end
    end
  end

  assign occ_o   = occ_q;
  assign valid_o = (occ_q != '0);
  assign data_o  = data_q[0];
  assign last_o  = valid_o & last_q[0];

endmodule

// File: rtl/bram_stream_reader.sv
// Reads `length` consecutive words from a BRAM read port starting at
// `base_addr` and emits them as a valid/ready stream with a last marker.
// The issue logic only launches a read when the skid buffer is guaranteed
// to have room for it one cycle later, so the buffer never overflows and
// the stream runs at one word per cycle when the sink is always ready.
// Optional stall counter output is enabled by BRAM_STREAM_READER_PERF_EN.
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [LEN_WIDTH-1:0]   length,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  bram_addr,
  input  logic [DATA_WIDTH-1:0]  bram_dout,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_last
`ifdef BRAM_STREAM_READER_PERF_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  pending_q, pending_d;
  logic                  pend_last_q, pend_last_d;

  logic [OCC_W-1:0]      occ;
  logic [OCC_W:0]        fill;
  logic                  pop;
  logic                  issue;
  logic                  skid_valid;
  logic                  skid_last;

  // Buffer holds the in-order words; the head drives the stream directly.
  bram_stream_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (pending_q),
    .push_data_i (bram_dout),
    .push_last_i (pend_last_q),
    .pop_i       (pop),
    .occ_o       (occ),
    .valid_o     (skid_valid),
    .data_o      (m_data),
    .last_o      (skid_last)
  );

  assign m_valid = skid_valid;
  assign m_last  = skid_last;
  assign pop     = skid_valid && m_ready;

  // Projected buffer fill one cycle from now, counting the read in flight.
  assign fill  = {1'b0, occ} + (OCC_W + 1)'(pending_q) - (OCC_W + 1)'(pop);
  assign issue = (state_q == RUN) && (issued_q < len_q) &&
                 (fill < (OCC_W + 1)'(SKID_DEPTH));

  // Next-state: command latch, address/count advance and completion detect.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    addr_d      = addr_q;
    pending_d   = issue;
    pend_last_d = pend_last_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            len_d    = length;
            addr_d   = base_addr;
            issued_d = '0;
            state_d  = RUN;
          end else begin
            state_d = FINISH;
          end
        end
      end
      RUN: begin
        if (issue) begin
          addr_d      = addr_q + 1'b1;
          issued_d    = issued_q + 1'b1;
          pend_last_d = (issued_q == len_q - 1'b1);
        end
        // Leave in the same cycle the final beat is taken by the sink.
        if ((issued_q == len_q) && !pending_q && (occ == OCC_W'(1)) && pop && skid_last) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers; reset drops any read in flight and returns to idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      addr_q      <= '0;
      pending_q   <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      addr_q      <= addr_d;
      pending_q   <= pending_d;
      pend_last_q <= pend_last_d;
    end
  end

  assign bram_addr = addr_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == FINISH);

`ifdef BRAM_STREAM_READER_PERF_EN
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  // Stall counter next value: clear on accepted start, count sink back-pressure.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && start) begin
      stall_d = '0;
    end else if (busy && skid_valid && !m_ready) begin
      stall_d = sat_inc(stall_q);
    end
  end

  // Stall counter register; keeps its value after done until the next start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule
